// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 8-digit 7-segment scan controller with frame-synchronous value commit.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module seg7_scan_ctrl #(
  parameter int unsigned CLK_DIV      = 100000,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter int unsigned CNT_W        = 17
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic [31:0] Value,
  input  logic        Load,
  output logic        Pending,
  output logic        FrameDone,
  output logic [6:0]  out7,
  output logic [7:0]  en_out
);

  typedef enum logic {BLANK, SHOW} state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [2:0]        digit, digit_n;
  logic [31:0]       shown, shown_n, staged;
  logic              boundary;
  logic [6:0]        seg_n;
  logic [7:0]        en_n;

  function automatic logic [6:0] dec(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h01;  4'h1: s = 7'h4F;  4'h2: s = 7'h12;  4'h3: s = 7'h06;
      4'h4: s = 7'h4C;  4'h5: s = 7'h24;  4'h6: s = 7'h20;  4'h7: s = 7'h0F;
      4'h8: s = 7'h00;  4'h9: s = 7'h04;  4'hA: s = 7'h08;  4'hB: s = 7'h60;
      4'hC: s = 7'h31;  4'hD: s = 7'h42;  4'hE: s = 7'h30;  4'hF: s = 7'h38;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  always_comb begin
    state_n  = state;
    cnt_n    = cnt + 1'b1;
    digit_n  = digit;
    boundary = 1'b0;
    case (state)
      BLANK: if (cnt == CNT_W'(BLANK_CYCLES - 1)) begin
        state_n = SHOW;
        cnt_n   = '0;
      end
      SHOW: if (cnt == CNT_W'(CLK_DIV - 1)) begin
        state_n  = BLANK;
        cnt_n    = '0;
        digit_n  = digit + 3'd1;
        boundary = (digit == 3'd7);
      end
      default: state_n = BLANK;
    endcase
  end

  // Outputs are decoded from next-state values so the registered outputs line up with state.
  always_comb begin
    shown_n = (boundary && Pending) ? staged : shown;
    en_n    = '1;
    seg_n   = '1;
    if (state_n == SHOW) begin
      en_n  = ~(8'b1 << digit_n);
      seg_n = dec(shown_n[{digit_n, 2'b00} +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
      if (digit_n != 3'd0 && (shown_n >> {digit_n, 2'b00}) == 32'd0)
        seg_n = '1;
`endif
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= BLANK;
      cnt       <= '0;
      digit     <= '0;
      shown     <= '0;
      staged    <= '0;
      Pending   <= 1'b0;
      FrameDone <= 1'b0;
      out7      <= '1;
      en_out    <= '1;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      digit     <= digit_n;
      shown     <= shown_n;
      FrameDone <= boundary;
      out7      <= seg_n;
      en_out    <= en_n;
      // A Load coinciding with a boundary wins: the old staged value commits, the new one waits.
      if (Load) begin
        staged  <= Value;
        Pending <= 1'b1;
      end else if (boundary) begin
        Pending <= 1'b0;
      end
    end
  end

endmodule
